// File: rtl/xlr8_dm_copy.sv
// Data-memory copy/fill engine sharing one memory port with the CPU.
// The CPU always has priority; the engine stalls in place while the CPU owns the port.
module xlr8_dm_copy #(
  parameter int DM_ADDR_W = 16
) (
  input  logic                 cp2,
  input  logic                 rst,
  input  logic [DM_ADDR_W-1:0] cpu_ramadr,
  input  logic                 cpu_ramre,
  input  logic                 cpu_ramwe,
  input  logic [7:0]           cpu_dbusout,
  input  logic                 start,
  input  logic                 fill,
  input  logic [DM_ADDR_W-1:0] src_addr,
  input  logic [DM_ADDR_W-1:0] dst_addr,
  input  logic [15:0]          len,
  input  logic [7:0]           fill_val,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 dm_ce,
  output logic                 dm_we,
  output logic [DM_ADDR_W-1:0] dm_address,
  output logic [7:0]           dm_din,
  input  logic [7:0]           dm_dout
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t               state_q, state_d;
  logic                 fill_q;
  logic [DM_ADDR_W-1:0] src_q, dst_q;
  logic [15:0]          len_q, idx_q;
  logic [7:0]           fill_val_q, hold_q;

  logic                 cpu_owns;
  logic                 last_byte;
  logic                 launch, capture, step;
  logic [DM_ADDR_W-1:0] idx_ext;

  assign cpu_owns  = cpu_ramre | cpu_ramwe;
  assign last_byte = (idx_q == len_q - 16'd1);
  assign idx_ext   = DM_ADDR_W'(idx_q);

  // Next-state logic; abort wins over any progress in the active states.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    capture = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != 16'd0) begin
            launch  = 1'b1;
            state_d = fill ? WR : RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: begin
        if (abort)          state_d = IDLE;
        else if (!cpu_owns) state_d = CAP;
      end
      CAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!cpu_owns) begin
          if (last_byte) begin
            state_d = DONE;
          end else begin
            step    = 1'b1;
            state_d = fill_q ? WR : RD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cp2) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 16'd0;
      hold_q     <= 8'd0;
      fill_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= 16'd0;
      fill_val_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        fill_q     <= fill;
        src_q      <= src_addr;
        dst_q      <= dst_addr;
        len_q      <= len;
        fill_val_q <= fill_val;
        idx_q      <= 16'd0;
      end else if (step) begin
        idx_q <= idx_q + 16'd1;
      end
      // dm_dout still reflects the RD address here, even if the CPU grabs the port now.
      if (capture) hold_q <= dm_dout;
    end
  end

  // Port mux: engine access is dropped during reset and in an aborting cycle.
  always_comb begin
    dm_ce      = 1'b0;
    dm_we      = 1'b0;
    dm_address = '0;
    dm_din     = 8'd0;
    if (cpu_owns) begin
      dm_ce      = 1'b1;
      dm_we      = cpu_ramwe;
      dm_address = cpu_ramadr;
      dm_din     = cpu_dbusout;
    end else if (!rst && !abort) begin
      case (state_q)
        RD: begin
          dm_ce      = 1'b1;
          dm_address = src_q + idx_ext;
        end
        WR: begin
          dm_ce      = 1'b1;
          dm_we      = 1'b1;
          dm_address = dst_q + idx_ext;
          dm_din     = fill_q ? fill_val_q : hold_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RD) || (state_q == CAP) || (state_q == WR);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_xlr8_dm_copy.sv
// Scoreboard bench for xlr8_dm_copy: a registered-address byte memory model sits on the
// port, expected engine writes are queued per operation and compared with observed ones.
module tb_xlr8_dm_copy;

  logic        cp2 = 1'b0;
  logic        rst;
  logic [15:0] cpu_ramadr;
  logic        cpu_ramre, cpu_ramwe;
  logic [7:0]  cpu_dbusout;
  logic        start, fill, abort;
  logic [15:0] src_addr, dst_addr, len;
  logic [7:0]  fill_val;
  logic        busy, done, dm_ce, dm_we;
  logic [15:0] dm_address;
  logic [7:0]  dm_din, dm_dout;

  typedef struct {
    int          rel;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  obs_ptr = 0;
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  done_rel, done_n;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q = 16'd0;

  xlr8_dm_copy #(.DM_ADDR_W(16)) dut (
    .cp2(cp2), .rst(rst),
    .cpu_ramadr(cpu_ramadr), .cpu_ramre(cpu_ramre), .cpu_ramwe(cpu_ramwe),
    .cpu_dbusout(cpu_dbusout),
    .start(start), .fill(fill), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill_val(fill_val), .abort(abort),
    .busy(busy), .done(done), .dm_ce(dm_ce), .dm_we(dm_we),
    .dm_address(dm_address), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  initial forever #5 cp2 = ~cp2;

  always @(posedge cp2) cyc <= cyc + 1;

  // Memory with a registered read address: data appears the cycle after the address.
  always @(posedge cp2) begin
    if (dm_ce) begin
      if (dm_we) mem[dm_address] <= dm_din;
      rd_q <= dm_address;
    end
  end
  assign dm_dout = mem[rd_q];

  // Record every engine-originated write with its cycle relative to the last start.
  always @(negedge cp2) begin
    if (dm_we && !(cpu_ramre || cpu_ramwe))
      obs_q.push_back('{cyc - t0, dm_address, dm_din});
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cpuWrite(input logic [15:0] a, input logic [7:0] d);
    @(posedge cp2); #1;
    cpu_ramwe = 1'b1; cpu_ramadr = a; cpu_dbusout = d;
    @(posedge cp2); #1;
    cpu_ramwe = 1'b0;
  endtask

  task automatic applyStimulus(input logic f, input logic [15:0] s, input logic [15:0] d,
                               input logic [15:0] n, input logic [7:0] fv);
    @(posedge cp2); #1;
    fill = f; src_addr = s; dst_addr = d; len = n; fill_val = fv;
    start = 1'b1; abort = 1'b0; rst = 1'b0; cpu_ramwe = 1'b0;
    t0 = cyc;
  endtask

  // Steps cycles 1..budget after a start; CPU writes at ca,ca+1 and cb,cb+1; kill by abort or rst.
  task automatic runOp(input int budget, input int ca, input int cb, input int kill_at,
                       input bit kill_rst, input int start_at, input logic exp_busy1);
    done_rel = -1;
    done_n   = 0;
    cpu_ramadr  = 16'h0050;
    cpu_dbusout = 8'h77;
    for (int rel = 1; rel <= budget; rel++) begin
      @(posedge cp2); #1;
      start = (rel == start_at);
      if (rel == start_at) begin
        dst_addr = 16'h0700; fill_val = 8'h11; len = 16'd2;
      end
      cpu_ramwe = (ca >= 0 && (rel == ca || rel == ca + 1)) ||
                  (cb >= 0 && (rel == cb || rel == cb + 1));
      abort = !kill_rst && (rel == kill_at);
      rst   = kill_rst && (rel == kill_at);
      @(negedge cp2);
      if (rel == 1) checkOutput("busy_c1", busy, exp_busy1);
      if (kill_at > 0 && rel == kill_at + 1) checkOutput("busy_after_kill", busy, 1'b0);
      if (done) begin
        done_n++;
        if (done_rel < 0) done_rel = rel;
      end
    end
    @(posedge cp2); #1;
    start = 1'b0; cpu_ramwe = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic checkWrites(input string tag);
    wr_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_ptr < obs_q.size()) begin
        o = obs_q[obs_ptr];
        obs_ptr++;
        checkOutput({tag, "_wr_cycle"}, o.rel, e.rel);
        checkOutput({tag, "_wr_addr"}, o.addr, e.addr);
        checkOutput({tag, "_wr_data"}, o.data, e.data);
      end else begin
        checkOutput({tag, "_wr_missing"}, obs_q.size(), obs_ptr + 1);
      end
    end
    checkOutput({tag, "_wr_extra"}, obs_q.size(), obs_ptr);
    obs_ptr = obs_q.size();
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; len = 16'd5; fill = 1'b0; abort = 1'b0;
    src_addr = 16'h0; dst_addr = 16'h0; fill_val = 8'h0;
    cpu_ramadr = 16'h0; cpu_ramre = 1'b0; cpu_ramwe = 1'b0; cpu_dbusout = 8'h0;

    // Reset holds everything quiet even with start asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge cp2);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_we", dm_we, 1'b0);
      checkOutput("rst_ce", dm_ce, 1'b0);
    end
    @(posedge cp2); #1;
    rst = 1'b0; start = 1'b0; len = 16'd0;
    @(negedge cp2);
    checkOutput("post_rst_busy", busy, 1'b0);

    cpuWrite(16'h0100, 8'hA1);
    cpuWrite(16'h0101, 8'hB2);
    cpuWrite(16'h0102, 8'hC3);
    cpuWrite(16'hFFFF, 8'h3C);
    cpuWrite(16'h0000, 8'hC3);
    cpuWrite(16'h0401, 8'hEE);
    cpuWrite(16'h0402, 8'hEE);
    cpuWrite(16'h0501, 8'hEE);
    cpuWrite(16'h0502, 8'hEE);
    obs_ptr = obs_q.size();

    // Uncontended copy: writes at 3, 6, 9 and done at 10.
    exp_q.push_back('{3, 16'h0200, 8'hA1});
    exp_q.push_back('{6, 16'h0201, 8'hB2});
    exp_q.push_back('{9, 16'h0202, 8'hC3});
    applyStimulus(1'b0, 16'h0100, 16'h0200, 16'd3, 8'h00);
    runOp(14, -1, -1, -1, 1'b0, -1, 1'b1);
    checkOutput("copy_done_cycle", done_rel, 10);
    checkOutput("copy_done_count", done_n, 1);
    checkWrites("copy");
    checkOutput("copy_mem0", mem[16'h0200], 8'hA1);
    checkOutput("copy_mem1", mem[16'h0201], 8'hB2);
    checkOutput("copy_mem2", mem[16'h0202], 8'hC3);

    // Fill with a start while busy that must not relatch.
    for (int i = 0; i < 4; i++) exp_q.push_back('{i + 1, 16'h0300 + 16'(i), 8'h5A});
    applyStimulus(1'b1, 16'h0000, 16'h0300, 16'd4, 8'h5A);
    runOp(8, -1, -1, -1, 1'b0, 2, 1'b1);
    checkOutput("fill_done_cycle", done_rel, 5);
    checkOutput("fill_done_count", done_n, 1);
    checkWrites("fill");
    for (int i = 0; i < 4; i++) checkOutput("fill_mem", mem[16'h0300 + 16'(i)], 8'h5A);

    // CPU contention: two stalled WR cycles push done out by two.
    exp_q.push_back('{4, 16'h0240, 8'hA1});
    exp_q.push_back('{7, 16'h0241, 8'hB2});
    exp_q.push_back('{11, 16'h0242, 8'hC3});
    applyStimulus(1'b0, 16'h0100, 16'h0240, 16'd3, 8'h00);
    runOp(16, 2, 9, -1, 1'b0, -1, 1'b1);
    checkOutput("cont_done_cycle", done_rel, 12);
    checkWrites("cont");
    checkOutput("cont_cpu_mem", mem[16'h0050], 8'h77);
    checkOutput("cont_mem0", mem[16'h0240], 8'hA1);
    checkOutput("cont_mem2", mem[16'h0242], 8'hC3);

    // Source address wraps from 0xFFFF to 0x0000.
    exp_q.push_back('{3, 16'h0010, 8'h3C});
    exp_q.push_back('{6, 16'h0011, 8'hC3});
    applyStimulus(1'b0, 16'hFFFF, 16'h0010, 16'd2, 8'h00);
    runOp(10, -1, -1, -1, 1'b0, -1, 1'b1);
    checkOutput("wrap_done_cycle", done_rel, 7);
    checkWrites("wrap");

    // len=0 no-op, plus a start during DONE that must be ignored.
    applyStimulus(1'b1, 16'h0100, 16'h0600, 16'd0, 8'h99);
    runOp(5, -1, -1, -1, 1'b0, 1, 1'b0);
    checkOutput("noop_done_cycle", done_rel, 1);
    checkOutput("noop_done_count", done_n, 1);
    checkOutput("noop_busy_after", busy, 1'b0);
    checkWrites("noop");

    // Abort in the second WR: only the first byte lands.
    exp_q.push_back('{3, 16'h0400, 8'hA1});
    applyStimulus(1'b0, 16'h0100, 16'h0400, 16'd3, 8'h00);
    runOp(12, -1, -1, 6, 1'b0, -1, 1'b1);
    checkOutput("abort_done_count", done_n, 0);
    checkWrites("abort");
    checkOutput("abort_mem0", mem[16'h0400], 8'hA1);
    checkOutput("abort_mem1", mem[16'h0401], 8'hEE);
    checkOutput("abort_mem2", mem[16'h0402], 8'hEE);

    // Same with reset in place of abort.
    exp_q.push_back('{3, 16'h0500, 8'hA1});
    applyStimulus(1'b0, 16'h0100, 16'h0500, 16'd3, 8'h00);
    runOp(12, -1, -1, 6, 1'b1, -1, 1'b1);
    checkOutput("rstkill_done_count", done_n, 0);
    checkWrites("rstkill");
    checkOutput("rstkill_mem0", mem[16'h0500], 8'hA1);
    checkOutput("rstkill_mem1", mem[16'h0501], 8'hEE);
    checkOutput("rstkill_mem2", mem[16'h0502], 8'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xlr8_dm_copy.md
XLR8_DM_COPY -- requirements
Module: xlr8_dm_copy

Interface
REQ-001 Parameter DM_ADDR_W, default 16: width of the data-memory byte address; all address arithmetic is modulo 2^DM_ADDR_W.
REQ-002 cp2  in  1  clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset; the only reset, synchronous, active-high.
REQ-004 cpu_ramadr  in  DM_ADDR_W  CPU data-memory address.
REQ-005 cpu_ramre  in  1  CPU read request, this cycle.
REQ-006 cpu_ramwe  in  1  CPU write request, this cycle.
REQ-007 cpu_dbusout  in  8  CPU write data.
REQ-008 start  in  1  one-cycle request to launch an operation.
REQ-009 fill  in  1  sampled with start; 1 = fill mode, 0 = copy mode.
REQ-010 src_addr  in  DM_ADDR_W  copy source base, sampled with start.
REQ-011 dst_addr  in  DM_ADDR_W  destination base, sampled with start.
REQ-012 len  in  16  byte count, sampled with start; 0 means no-op.
REQ-013 fill_val  in  8  fill byte, sampled with start.
REQ-014 abort  in  1  synchronous cancel of the running operation.
REQ-015 busy  out  1  operation in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 dm_ce, dm_we  out  1 each  memory clock enable and write enable.
REQ-018 dm_address  out  DM_ADDR_W  memory address.
REQ-019 dm_din  out  8  memory write data.
REQ-020 dm_dout  in  8  memory read data; valid in the cycle after the read address is presented (registered address).

Function
REQ-021 The block SHALL implement the states IDLE, RD, CAP, WR and DONE.
REQ-022 Port mux (combinational): when cpu_ramre or cpu_ramwe is 1, the CPU owns the port.
- dm_address=cpu_ramadr, dm_din=cpu_dbusout, dm_we=cpu_ramwe, dm_ce=1.
- The engine stalls and holds its state and index.
REQ-023 Otherwise, the engine drives the port in RD and WR (dm_ce=1, dm_we=1 only in WR); in all other cases dm_ce=0 and dm_we=0.
REQ-024 IDLE:
- start=1 with len≠0: latch inputs, index:=0, go to RD (copy) or WR (fill).
- start=1 with len=0: go to DONE.
- busy=0.
REQ-025 RD: when the port is free, dm_address=src+index, then go to CAP; otherwise stay in RD.
REQ-026 CAP: capture dm_dout into the hold register unconditionally, without any port access, then go to WR.
- The captured data stays valid even if the CPU owns the port in CAP.
REQ-027 WR: when the port is free, write dm_address=dst+index with dm_din = hold register (copy) or fill_val (fill).
- If index=len-1, go to DONE.
- Otherwise increment index and go to RD (copy) or stay in WR (fill).
- When the port is not free, stay in WR.
REQ-028 DONE lasts one cycle with done=1 and busy=0, then goes to IDLE.
REQ-029 busy=1 exactly in RD, CAP and WR.
REQ-030 start while busy or in DONE SHALL be ignored, with no relatch.
REQ-031 Address sums SHALL wrap modulo 2^DM_ADDR_W; len is unsigned; len=65535 is legal.
REQ-032 Copy proceeds in ascending addresses; overlapping regions with dst>src SHALL replicate source bytes.
REQ-033 abort=1 in RD, CAP or WR SHALL force IDLE on the next edge.
- The write of the current cycle is suppressed.
- done is not pulsed.
- abort in IDLE or DONE has no effect.
REQ-034 Uncontended throughput SHALL be 3 cycles per byte for copy and 1 cycle per byte for fill.

Reset
REQ-035 rst=1 SHALL force IDLE, index=0, hold register=0, busy=0 and done=0 on the next edge.
- dm_we stays 0 throughout rst unless the CPU owns the port.
REQ-036 rst SHALL override start and abort, including mid-operation; no engine write may occur in the cycle after rst deasserts.

Verification
REQ-037 Copy, no CPU traffic: mem[0x100..0x102]=A1,B2,C3; start at cycle 0 with src=0x100, dst=0x200, len=3.
- Response: writes at cycles 3, 6 and 9; done=1 at cycle 10; mem[0x200..0x202]=A1,B2,C3.
REQ-038 Fill: dst=0x300, len=4, fill_val=0x5A, start at cycle 0.
- Response: dm_we=1 at cycles 1-4; done at cycle 5; mem[0x300..0x303]=5A.
REQ-039 CPU contention: during the copy of REQ-037, assert cpu_ramwe (addr 0x050, data 0x77) in every CAP and WR cycle for 2 cycles.
- Response: CPU write lands; copy result unchanged; done delayed by the stall count.
REQ-040 Wrap and no-op: src=0xFFFF, dst=0x0010, len=2 copies mem[0xFFFF] and mem[0x0000].
- A separate start with len=0 gives done=1 on the next cycle with no dm_we.
REQ-041 Abort/reset mid-copy: abort in the second WR of a len=3 copy.
- Response: only the first byte is written; busy=0 on the next cycle; no done.
- Repeat with rst in place of abort: same result.
